// File: rtl/bpred_upd_sched_if.sv
// Bundle of every non-clock signal of the branch-predictor update scheduler.
//   wb_*        : WB late-resolution report (indirects/returns), valid/ready handshake
//   ex_*        : EX resolution report, valid/ready handshake
//   upd_hold    : suppress issue this cycle
//   flush       : discard queued and incoming reports
//   upd_*       : registered update outputs to the predictor's update_* inputs
//   q_count     : FIFO occupancy
//   mispred_cnt : saturating count of issued mispredicted updates
// master = report sources / predictor side, slave = the scheduler.
interface bpred_upd_sched_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            wb_valid;
  logic [31:0]     wb_neip;
  logic [31:0]     wb_target;
  logic            wb_taken;
  logic            wb_mispred;
  logic            wb_ready;

  logic            ex_valid;
  logic [31:0]     ex_neip;
  logic [31:0]     ex_target;
  logic            ex_taken;
  logic            ex_mispred;
  logic            ex_ready;

  logic            upd_hold;
  logic            flush;

  logic            upd_valid;
  logic [31:0]     upd_neip;
  logic [31:0]     upd_target;
  logic            upd_taken;
  logic            upd_mispred;
  logic [CW-1:0]   q_count;
  logic [CNTW-1:0] mispred_cnt;

  modport master (
    output wb_valid, wb_neip, wb_target, wb_taken, wb_mispred,
    output ex_valid, ex_neip, ex_target, ex_taken, ex_mispred,
    output upd_hold, flush,
    input  wb_ready, ex_ready,
    input  upd_valid, upd_neip, upd_target, upd_taken, upd_mispred,
    input  q_count, mispred_cnt
  );

  modport slave (
    input  wb_valid, wb_neip, wb_target, wb_taken, wb_mispred,
    input  ex_valid, ex_neip, ex_target, ex_taken, ex_mispred,
    input  upd_hold, flush,
    output wb_ready, ex_ready,
    output upd_valid, upd_neip, upd_target, upd_taken, upd_mispred,
    output q_count, mispred_cnt
  );
endinterface

// File: rtl/bpred_upd_sched.sv
// Branch-predictor update scheduler.
// Buffers resolved-branch reports from WB (older) and EX (younger) in a small in-order FIFO
// and issues at most one update per cycle on registered upd_* outputs.
//   CLK   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : bpred_upd_sched_if.slave (report handshakes, hold/flush, update outputs,
//           occupancy and saturating mispredict counter)
module bpred_upd_sched #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 16
) (
  input logic                CLK,
  input logic                reset,
  bpred_upd_sched_if.slave   bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Entry layout: {neip, target, taken, mispred}
  logic [65:0]     mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic            upd_valid_q;
  logic [65:0]     upd_entry_q;
  logic [CNTW-1:0] mispred_cnt_q;

  logic [CW-1:0]   free;
  logic [CW-1:0]   ex_need;
  logic            wb_ready, ex_ready;
  logic            wb_acc, ex_acc, deq;
  logic [PW-1:0]   ex_ptr;
  logic [65:0]     wb_entry, ex_entry, head_entry;

  // Ready looks only at registered occupancy, so a same-cycle dequeue never opens a slot.
  // EX needs room for WB's entry too whenever WB is presenting, keeping program order.
  always_comb begin
    free     = CW'(DEPTH) - count_q;
    ex_need  = CW'(1) + CW'(bus.wb_valid);
    wb_ready = !bus.flush && (free >= CW'(1));
    ex_ready = !bus.flush && (free >= ex_need);
  end

  always_comb begin
    wb_acc     = bus.wb_valid && wb_ready;
    ex_acc     = bus.ex_valid && ex_ready;
    deq        = !bus.flush && !bus.upd_hold && (count_q != '0);
    wb_entry   = {bus.wb_neip, bus.wb_target, bus.wb_taken, bus.wb_mispred};
    ex_entry   = {bus.ex_neip, bus.ex_target, bus.ex_taken, bus.ex_mispred};
    ex_ptr     = tail_q + PW'(wb_acc);
    head_entry = mem_q[head_q];
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(deq);
      tail_d  = tail_q + PW'(wb_acc) + PW'(ex_acc);
      count_d = count_q + CW'(wb_acc) + CW'(ex_acc) - CW'(deq);
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge CLK) begin
    if (wb_acc) mem_q[tail_q] <= wb_entry;
    if (ex_acc) mem_q[ex_ptr] <= ex_entry;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload holds its last value when nothing issues; only upd_valid pulses.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      upd_valid_q   <= 1'b0;
      upd_entry_q   <= '0;
      mispred_cnt_q <= '0;
    end else begin
      upd_valid_q <= deq;
      if (deq) begin
        upd_entry_q <= head_entry;
        if (head_entry[0] && (mispred_cnt_q != '1)) begin
          mispred_cnt_q <= mispred_cnt_q + CNTW'(1);
        end
      end
    end
  end

  assign bus.wb_ready    = wb_ready;
  assign bus.ex_ready    = ex_ready;
  assign bus.upd_valid   = upd_valid_q;
  assign bus.upd_neip    = upd_entry_q[65:34];
  assign bus.upd_target  = upd_entry_q[33:2];
  assign bus.upd_taken   = upd_entry_q[1];
  assign bus.upd_mispred = upd_entry_q[0];
  assign bus.q_count     = count_q;
  assign bus.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_bpred_upd_sched.sv
module tb_bpred_upd_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bpred_upd_sched_if #(.DEPTH(4), .CNTW(16)) bus ();

  bpred_upd_sched #(.DEPTH(4), .CNTW(16)) dut (
    .CLK   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [65:0] sb[$];
  logic [15:0] exp_mis = 16'h0;
  bit last_wa, last_ea;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every update pulse must match the oldest outstanding report.
  always @(posedge clk) begin
    #1;
    if (rst_n && bus.upd_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_upd: got upd_valid=1 expected no pending report");
      end else begin
        logic [65:0] e;
        e = sb.pop_front();
        chk("upd_payload", {bus.upd_neip, bus.upd_target, bus.upd_taken, bus.upd_mispred}, e);
        if (e[0] && exp_mis != 16'hFFFF) exp_mis = exp_mis + 16'h1;
        chk("mispred_cnt", 66'(bus.mispred_cnt), 66'(exp_mis));
      end
    end
  end

  task automatic set_wb(input bit v, input logic [31:0] n, input logic [31:0] t,
                        input bit tk, input bit m);
    bus.wb_valid = v; bus.wb_neip = n; bus.wb_target = t; bus.wb_taken = tk; bus.wb_mispred = m;
  endtask

  task automatic set_ex(input bit v, input logic [31:0] n, input logic [31:0] t,
                        input bit tk, input bit m);
    bus.ex_valid = v; bus.ex_neip = n; bus.ex_target = t; bus.ex_taken = tk; bus.ex_mispred = m;
  endtask

  // One clock cycle from negedge to negedge; records handshakes into the scoreboard.
  task automatic tick();
    logic [65:0] we, ee;
    bit fl;
    #1;
    last_wa = bus.wb_valid && bus.wb_ready;
    last_ea = bus.ex_valid && bus.ex_ready;
    we = {bus.wb_neip, bus.wb_target, bus.wb_taken, bus.wb_mispred};
    ee = {bus.ex_neip, bus.ex_target, bus.ex_taken, bus.ex_mispred};
    fl = bus.flush;
    @(posedge clk);
    if (fl) sb.delete();
    if (last_wa) sb.push_back(we);
    if (last_ea) sb.push_back(ee);
    @(negedge clk);
  endtask

  task automatic offer_ex(input logic [31:0] n, input logic [31:0] t, input bit tk, input bit m);
    int k;
    set_ex(1'b1, n, t, tk, m);
    k = 0;
    do begin
      tick();
      k++;
    end while (!last_ea && k < 20);
    if (!last_ea) begin
      checks++; errors++;
      $display("FAIL offer_timeout: got no ex accept expected accept within 20 cycles");
    end
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 12) begin
      tick();
      k++;
    end
    tick();
    chk("drain_empty", 66'(sb.size()), 66'(0));
    chk("drain_q_count", 66'(bus.q_count), 66'(0));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int need, got, cyc;
    set_wb(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    bus.upd_hold = 1'b0;
    bus.flush = 1'b0;
    #3;
    chk("rst_upd_valid", 66'(bus.upd_valid), 66'(0));
    chk("rst_q_count", 66'(bus.q_count), 66'(0));
    chk("rst_mispred_cnt", 66'(bus.mispred_cnt), 66'(0));
    chk("rst_payload", {bus.upd_neip, bus.upd_target, bus.upd_taken, bus.upd_mispred}, 66'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single EX report, no bypass
    set_ex(1'b1, 32'h1008, 32'h2000, 1'b1, 1'b1);
    #1 chk("t1_ex_ready", 66'(bus.ex_ready), 66'(1));
    tick();
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1 chk("t1_q_count_1", 66'(bus.q_count), 66'(1));
    chk("t1_no_bypass", 66'(bus.upd_valid), 66'(0));
    tick();
    #1 chk("t1_q_count_0", 66'(bus.q_count), 66'(0));
    chk("t1_mispred_cnt", 66'(bus.mispred_cnt), 66'(1));
    chk("t1_upd_neip", 66'(bus.upd_neip), 66'(32'h1008));

    // WB and EX together, WB older
    set_wb(1'b1, 32'h3000, 32'h3100, 1'b0, 1'b0);
    set_ex(1'b1, 32'h4000, 32'h4200, 1'b1, 1'b0);
    #1 chk("t2_wb_ready", 66'(bus.wb_ready), 66'(1));
    chk("t2_ex_ready", 66'(bus.ex_ready), 66'(1));
    tick();
    set_wb(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1 chk("t2_q_count_2", 66'(bus.q_count), 66'(2));
    drain();

    // Hold with 5 EX reports into a 4-deep FIFO
    bus.upd_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_ex(1'b1, 32'h5000 + 32'(i * 8), 32'h6000 + 32'(i), 1'(i), 1'(i == 2));
      #1 chk("t3_ex_ready_fill", 66'(bus.ex_ready), 66'(1));
      tick();
    end
    set_ex(1'b1, 32'h5020, 32'h6004, 1'b1, 1'b1);
    #1 chk("t3_ex_ready_full", 66'(bus.ex_ready), 66'(0));
    chk("t3_q_count_4", 66'(bus.q_count), 66'(4));
    tick();
    #1 chk("t3_frozen_count", 66'(bus.q_count), 66'(4));
    chk("t3_frozen_valid", 66'(bus.upd_valid), 66'(0));
    bus.upd_hold = 1'b0;
    chk("t3_ready_after_release", 66'(bus.ex_ready), 66'(0));
    tick();
    #1 chk("t3_ready_after_issue", 66'(bus.ex_ready), 66'(1));
    tick();
    chk("t3_fifth_accepted", 66'(last_ea), 66'(1));
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1 chk("t3_q_count_3", 66'(bus.q_count), 66'(3));
    drain();

    // q_count=3 with both sources valid
    bus.upd_hold = 1'b1;
    offer_ex(32'h8000, 32'h8100, 1'b0, 1'b0);
    offer_ex(32'h8004, 32'h8104, 1'b1, 1'b0);
    offer_ex(32'h8008, 32'h8108, 1'b0, 1'b1);
    set_wb(1'b1, 32'h9000, 32'h9100, 1'b1, 1'b0);
    set_ex(1'b1, 32'hA000, 32'hA100, 1'b0, 1'b1);
    bus.upd_hold = 1'b0;
    #1 chk("t4_wb_ready", 66'(bus.wb_ready), 66'(1));
    chk("t4_ex_ready", 66'(bus.ex_ready), 66'(0));
    tick();
    set_wb(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1 chk("t4_q_count_3", 66'(bus.q_count), 66'(3));
    chk("t4_ex_ready_now", 66'(bus.ex_ready), 66'(1));
    tick();
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drain();

    // Flush with q_count=3 and EX pending
    bus.upd_hold = 1'b1;
    offer_ex(32'hB000, 32'hB100, 1'b1, 1'b1);
    offer_ex(32'hB004, 32'hB104, 1'b1, 1'b1);
    offer_ex(32'hB008, 32'hB108, 1'b1, 1'b1);
    set_ex(1'b1, 32'hC000, 32'hC100, 1'b1, 1'b1);
    bus.flush = 1'b1;
    #1 chk("t5_ex_ready", 66'(bus.ex_ready), 66'(0));
    chk("t5_wb_ready", 66'(bus.wb_ready), 66'(0));
    tick();
    bus.flush = 1'b0;
    bus.upd_hold = 1'b0;
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1 chk("t5_q_count_0", 66'(bus.q_count), 66'(0));
    chk("t5_upd_valid", 66'(bus.upd_valid), 66'(0));
    chk("t5_mispred_kept", 66'(bus.mispred_cnt), 66'(exp_mis));
    tick();
    #1 chk("t5_no_issue", 66'(bus.upd_valid), 66'(0));

    // Bulk mispredicts up to 16'hFFFC
    need = 32'h0000FFFC - int'(exp_mis);
    got = 0;
    cyc = 0;
    set_ex(1'b1, 32'h7000, 32'h7100, 1'b1, 1'b1);
    while (got < need && cyc < need + 50) begin
      tick();
      if (last_ea) got++;
      cyc++;
    end
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("bulk_accepted", 66'(got), 66'(need));
    drain();
    chk("cnt_fffc", 66'(bus.mispred_cnt), 66'(16'hFFFC));
    offer_ex(32'h7008, 32'h7108, 1'b0, 1'b1);
    offer_ex(32'h700C, 32'h710C, 1'b1, 1'b1);
    drain();
    chk("cnt_fffe", 66'(bus.mispred_cnt), 66'(16'hFFFE));
    for (int i = 0; i < 3; i++) offer_ex(32'h7010 + 32'(i * 4), 32'h7110, 1'b1, 1'b1);
    drain();
    chk("cnt_sat", 66'(bus.mispred_cnt), 66'(16'hFFFF));

    // Reset mid-stream, outputs clear without an edge
    bus.upd_hold = 1'b1;
    offer_ex(32'hD000, 32'hD100, 1'b1, 1'b1);
    offer_ex(32'hD004, 32'hD104, 1'b1, 1'b0);
    bus.upd_hold = 1'b0;
    @(posedge clk);
    #2;
    chk("t7_pre_valid", 66'(bus.upd_valid), 66'(1));
    rst_n = 1'b0;
    #1;
    chk("t7_upd_valid", 66'(bus.upd_valid), 66'(0));
    chk("t7_q_count", 66'(bus.q_count), 66'(0));
    chk("t7_mispred_cnt", 66'(bus.mispred_cnt), 66'(0));
    chk("t7_payload", {bus.upd_neip, bus.upd_target, bus.upd_taken, bus.upd_mispred}, 66'(0));
    sb.delete();
    exp_mis = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    #1 chk("t7_after_valid", 66'(bus.upd_valid), 66'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bpred_upd_sched.md
Name: bpred_upd_sched

Overview:
Update scheduler for the branch predictor's training port. It collects resolved-branch reports from two pipeline sources: EX resolution, and WB late resolution for indirects and returns. Reports are buffered in a small FIFO in program order, and one update per cycle is issued on registered outputs that drive the predictor's update_* inputs. The block also supports hold-off and flush, and keeps a saturating mispredict counter.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
CNTW, 16, mispredict counter width

Ports:
CLK  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
wb_valid  in  1  WB resolution report present
wb_neip  in  32  next-EIP of the resolved branch
wb_target  in  32  resolved target
wb_taken  in  1  resolved direction
wb_mispred  in  1  branch was mispredicted
wb_ready  out  1  WB report accepted this cycle
ex_valid  in  1  EX resolution report present
ex_neip  in  32  as wb_neip
ex_target  in  32  as wb_target
ex_taken  in  1  as wb_taken
ex_mispred  in  1  as wb_mispred
ex_ready  out  1  EX report accepted this cycle
upd_hold  in  1  suppress issue this cycle
flush  in  1  discard all queued and incoming reports
upd_valid  out  1  to predictor update_valid
upd_neip  out  32  to update_neip
upd_target  out  32  to update_target
upd_taken  out  1  to update_taken
upd_mispred  out  1  to update_mispred
q_count  out  log2(DEPTH)+1  current FIFO occupancy
mispred_cnt  out  CNTW  issued mispredicted updates, saturating

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers and q_count are 0.
  - upd_valid, upd_taken and upd_mispred are 0.
  - upd_neip and upd_target are 32'h0.
  - mispred_cnt is 0.
- Each FIFO entry is 66 bits: {neip, target, taken, mispred}.
- Ordering:
  - WB reports are older than EX reports.
  - When both are accepted in the same cycle, the WB entry is written at the tail and the EX entry at tail+1.
- Ready logic (combinational, from registered count only; no dependence on same-cycle dequeue):
  - free = DEPTH - q_count.
  - wb_ready = !flush && (free >= 1).
  - ex_ready = !flush && (free >= 1 + wb_valid).
  - EX is therefore never accepted ahead of a refused WB report.
- Handshake:
  - A report is accepted on a rising edge where valid && ready.
  - A source must hold its valid and payload stable until accepted.
  - Up to 2 enqueues per cycle.
- Issue:
  - At a rising edge with flush=0, upd_hold=0 and q_count>0, the head entry loads into the upd_* registers, upd_valid goes to 1 and the head pointer advances by 1.
  - Otherwise upd_valid goes to 0; the payload registers hold their value.
  - At most one issue per cycle. upd_valid is a single-cycle pulse per entry.
- Latency:
  - A report accepted at edge N is issuable at edge N+1 at the earliest, giving upd_valid high in the cycle after N+1 (no bypass).
- q_count:
  - Next value = q_count + enqueues - dequeue, evaluated at the same edge.
  - It never exceeds DEPTH; a simultaneous enqueue into the last slot and a dequeue is legal.
- Pointers:
  - log2(DEPTH) bits, wrap modulo DEPTH.
  - Full and empty are distinguished by q_count, not by pointer comparison.
- Flush (synchronous, highest priority):
  - At the edge, both pointers and q_count go to 0.
  - No enqueue and no issue occur; upd_valid goes to 0.
  - mispred_cnt is unchanged.
  - upd_hold is ignored.
- mispred_cnt:
  - Increments by 1 at each edge that issues an entry with mispred=1.
  - Saturates at all-ones.
  - Cleared only by reset.
- upd_hold=1 with a full FIFO: both ready outputs are 0 and the FIFO stays frozen. No overflow and no data loss.
- Reset asserted mid-operation: all state clears immediately, and upd_valid drops without waiting for a clock edge.

Test Plan:
- Reset, then EX report {neip=32'h1008, target=32'h2000, taken=1, mispred=1} at edge 1 → q_count=1 after edge 1. upd_valid=1 in the cycle after edge 2, with the same payload. mispred_cnt=1 and q_count=0 after edge 2.
- wb_valid and ex_valid in the same cycle with an empty FIFO → both ready=1. Issues follow on consecutive cycles, WB payload first, then EX.
- upd_hold=1 while 5 EX reports are offered, DEPTH=4 → 4 accepted, q_count=4, ex_ready=0 on the 5th. Release the hold → 4 upd_valid pulses in order; the 5th report is accepted the cycle after the first issue.
- q_count=3, both sources valid → wb_ready=1, ex_ready=0. After the edge, q_count=4, or 3 if the same edge issued.
- Flush with q_count=3 while ex_valid=1 → ex_ready=0. q_count=0 and upd_valid=0 after the edge; the EX report is not enqueued.
- Preload mispred_cnt to 16'hFFFE via 2 issued mispredicts before the final step, then issue 3 more mispredicts → counter reads 16'hFFFF and stays there. Assert reset mid-stream → all outputs are zero without a clock edge.
